// File: rtl/display_share_arbiter.sv
// rtl/display_share_arbiter.sv - round-robin display owner arbiter with minimum dwell
// Optional: DISP_ARB_PRIORITY_EN makes requester 0 urgent (preempts, never dwell-displaced).
module display_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int DIGITS      = 4,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req,
    input  logic [NREQ*DIGITS*4-1:0]          req_val,
    output logic [NREQ-1:0]                   gnt,
    output logic [DIGITS*4-1:0]               disp_val,
    output logic                              disp_valid,
    output logic [((NREQ>1)?$clog2(NREQ):1)-1:0] disp_owner
);
    localparam int W  = DIGITS * 4;
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);
`ifdef DISP_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [OW-1:0]   rr_ptr, rr_nxt, owner_inc, owner_nxt, win_idx;
    logic [NREQ-1:0] gnt_nxt, others;
    logic [W-1:0]    val_nxt;
    logic            valid_nxt, do_grant;
    logic [OW:0]     pick_idle, pick_next;
    logic [W-1:0]    vals [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign vals[k] = req_val[k*W +: W];
    end

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] start);
        logic [OW:0]   res;
        logic [OW-1:0] k;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = OW'((int'(start) + i) % NREQ);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign owner_inc = (disp_owner == OW'(NREQ - 1)) ? '0 : disp_owner + 1'b1;
    assign others    = req & ~gnt;
    assign pick_idle = rr_pick(req, rr_ptr);
    assign pick_next = rr_pick(others, owner_inc);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rr_nxt    = rr_ptr;
        gnt_nxt   = gnt;
        owner_nxt = disp_owner;
        valid_nxt = disp_valid;
        val_nxt   = disp_val;
        do_grant  = 1'b0;
        win_idx   = '0;
        case (state)
            IDLE: begin
                if (PRIO && req[0]) begin
                    do_grant = 1'b1;
                end else if (|req) begin
                    do_grant = 1'b1;
                    win_idx  = pick_idle[OW-1:0];
                end
            end
            OWN: begin
                if (PRIO && req[0] && disp_owner != '0) begin
                    // Preemption leaves the pointer alone unless the owner also left.
                    do_grant = 1'b1;
                    if (!req[disp_owner]) rr_nxt = owner_inc;
                end else if (!req[disp_owner]) begin
                    rr_nxt = owner_inc;
                    if (pick_next[OW]) begin
                        do_grant = 1'b1;
                        win_idx  = pick_next[OW-1:0];
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        valid_nxt = 1'b0;
                    end
                end else if (cnt == CNT_MAX && |others && !(PRIO && disp_owner == '0)) begin
                    do_grant = 1'b1;
                    win_idx  = pick_next[OW-1:0];
                    rr_nxt   = owner_inc;
                end else begin
                    val_nxt = vals[disp_owner];
                    if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (do_grant) begin
            state_nxt = OWN;
            gnt_nxt   = NREQ'(1) << win_idx;
            owner_nxt = win_idx;
            valid_nxt = 1'b1;
            val_nxt   = vals[win_idx];
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rr_ptr     <= '0;
            gnt        <= '0;
            disp_owner <= '0;
            disp_valid <= 1'b0;
            disp_val   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rr_ptr     <= rr_nxt;
            gnt        <= gnt_nxt;
            disp_owner <= owner_nxt;
            disp_valid <= valid_nxt;
            disp_val   <= val_nxt;
        end
    end
endmodule

// File: tb/tb_display_share_arbiter.sv
// tb/tb_display_share_arbiter.sv - directed scoreboard bench for display_share_arbiter
module tb_display_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_val;
    logic [3:0]  gnt;
    logic [15:0] disp_val;
    logic        disp_valid;
    logic [1:0]  disp_owner;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [3:0]  gnt;
        logic [1:0]  own;
        logic        valid;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    display_share_arbiter #(.NREQ(4), .DIGITS(4), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_val(req_val),
        .gnt(gnt), .disp_val(disp_val), .disp_valid(disp_valid), .disp_owner(disp_owner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int k, input logic [15:0] v);
        req_val[k*16 +: 16] = v;
    endtask

    task automatic push(input string tag, input logic [3:0] g, input logic [1:0] o,
                        input logic v, input logic [15:0] d);
        exp_t e;
        e.tag = tag; e.gnt = g; e.own = o; e.valid = v; e.val = d;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step one edge, then compare the DUT against the oldest scoreboard entry.
    task automatic step_check();
        exp_t e;
        step();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".gnt"},   32'(gnt),        32'(e.gnt));
            chk({e.tag, ".owner"}, 32'(disp_owner), 32'(e.own));
            chk({e.tag, ".valid"}, 32'(disp_valid), 32'(e.valid));
            chk({e.tag, ".val"},   32'(disp_val),   32'(e.val));
        end
    endtask

    initial begin
        logic [15:0] vtab [4];
        int o;
        vtab[0] = 16'hA000; vtab[1] = 16'hA111; vtab[2] = 16'h1234; vtab[3] = 16'hA333;
        rst = 1'b1; req = '0; req_val = '0;
        for (int k = 0; k < 4; k++) set_val(k, vtab[k]);
        step();
        push("reset", 4'b0000, 2'd0, 1'b0, 16'h0000);
        step_check();

        // Single requester, then live value update
        rst = 1'b0; req = 4'b0100;
        push("t1_grant", 4'b0100, 2'd2, 1'b1, 16'h1234);
        step_check();
        set_val(2, 16'hBEEF);
        push("t1_live", 4'b0100, 2'd2, 1'b1, 16'hBEEF);
        step_check();

        // Owner drop to idle, then wrap from pointer 3 to requester 0
        req = 4'b0000;
        push("t4_drop", 4'b0000, 2'd2, 1'b0, 16'hBEEF);
        step_check();
        req = 4'b0101;
        push("t4_wrap", 4'b0001, 2'd0, 1'b1, 16'hA000);
        step_check();

        // Full contention rotates 0,1,2,3,0 at four cycles each
        rst = 1'b1; req = '0; step();
        rst = 1'b0; set_val(2, vtab[2]); req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            o = (c / 4) % 4;
            push($sformatf("t2_rot%0d", c), 4'(1 << o), 2'(o), 1'b1, vtab[o]);
            step_check();
        end

        // Lone owner saturates, newcomer takes over on the next edge
        rst = 1'b1; req = '0; step();
        rst = 1'b0; req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            push("t3_alone", 4'b0010, 2'd1, 1'b1, vtab[1]);
            step_check();
        end
        req = 4'b1010;
        push("t3_handoff", 4'b1000, 2'd3, 1'b1, vtab[3]);
        step_check();

        // Owner 3 drops, 1 wins; reset mid-ownership; re-request after reset
        req = 4'b0010;
        push("t5_pre", 4'b0010, 2'd1, 1'b1, vtab[1]);
        step_check();
        rst = 1'b1;
        push("t5_reset", 4'b0000, 2'd0, 1'b0, 16'h0000);
        step_check();
        rst = 1'b0;
        push("t5_regrant", 4'b0010, 2'd1, 1'b1, vtab[1]);
        step_check();

        // Requester 0 arrives while 3 owns
        rst = 1'b1; req = '0; step();
        rst = 1'b0; req = 4'b1000;
        push("t6_own3", 4'b1000, 2'd3, 1'b1, vtab[3]);
        step_check();
        push("t6_own3b", 4'b1000, 2'd3, 1'b1, vtab[3]);
        step_check();
        req = 4'b1001;
        for (int c = 0; c < 3; c++) begin
`ifdef DISP_ARB_PRIORITY_EN
            push($sformatf("t6_prio%0d", c), 4'b0001, 2'd0, 1'b1, vtab[0]);
`else
            if (c < 2) push($sformatf("t6_rr%0d", c), 4'b1000, 2'd3, 1'b1, vtab[3]);
            else       push($sformatf("t6_rr%0d", c), 4'b0001, 2'd0, 1'b1, vtab[0]);
`endif
            step_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
